// File: rtl/rf_write_sequencer.sv
// Register-file write sequencer: turns normal, CALL-link and trap-entry requests
// into one or two write-port cycles, with stall handling and a deferred trap.
module rf_write_sequencer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Norm_Req,
  input  logic       Call_Req,
  input  logic       Trap_Req,
  input  logic [4:0] IR_RD,
  input  logic       Stall,
  output logic [2:0] MUX_RFDest,
  output logic [1:0] MUX_RFSrc,
  output logic       RF_Write_En,
  output logic       Busy,
  output logic       Done
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WR_NORM     = 3'd1;
  localparam logic [2:0] S_WR_CALL     = 3'd2;
  localparam logic [2:0] S_WR_TRAP_PC  = 3'd3;
  localparam logic [2:0] S_WR_TRAP_NPC = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam logic [2:0] DEST_IR_RD = 3'b000;
  localparam logic [2:0] DEST_G0    = 3'b001;
  localparam logic [2:0] DEST_R15   = 3'b010;
  localparam logic [2:0] DEST_R17   = 3'b011;
  localparam logic [2:0] DEST_R18   = 3'b100;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_PC  = 2'b01;
  localparam logic [1:0] SRC_NPC = 2'b10;

  logic [2:0] state_q, state_d;
  logic [4:0] rdLatch_q, rdLatch_d;
  logic       trapPend_q, trapPend_d;
  logic       wrState;

  always_comb begin
    state_d    = state_q;
    rdLatch_d  = rdLatch_q;
    trapPend_d = trapPend_q;
    case (state_q)
      S_IDLE: begin
        if (Trap_Req) begin
          state_d = S_WR_TRAP_PC;
        end else if (Call_Req) begin
          state_d = S_WR_CALL;
        end else if (Norm_Req) begin
          state_d   = S_WR_NORM;
          rdLatch_d = IR_RD;
        end
      end
      // A trap arriving during a single write is remembered and run right after DONE.
      S_WR_NORM, S_WR_CALL: begin
        if (Trap_Req) trapPend_d = 1'b1;
        if (!Stall)   state_d    = S_DONE;
      end
      S_WR_TRAP_PC: begin
        if (!Stall) state_d = S_WR_TRAP_NPC;
      end
      S_WR_TRAP_NPC: begin
        if (!Stall) state_d = S_DONE;
      end
      S_DONE: begin
        if (trapPend_q) begin
          state_d    = S_WR_TRAP_PC;
          trapPend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      rdLatch_q  <= 5'd0;
      trapPend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdLatch_q  <= rdLatch_d;
      trapPend_q <= trapPend_d;
    end
  end

  // Writes to G0 are steered to the G0 select with the strobe suppressed.
  always_comb begin
    MUX_RFDest = DEST_G0;
    MUX_RFSrc  = SRC_ALU;
    wrState    = 1'b0;
    case (state_q)
      S_WR_NORM: begin
        if (rdLatch_q != 5'd0) begin
          MUX_RFDest = DEST_IR_RD;
          wrState    = 1'b1;
        end
      end
      S_WR_CALL: begin
        MUX_RFDest = DEST_R15;
        MUX_RFSrc  = SRC_PC;
        wrState    = 1'b1;
      end
      S_WR_TRAP_PC: begin
        MUX_RFDest = DEST_R17;
        MUX_RFSrc  = SRC_PC;
        wrState    = 1'b1;
      end
      S_WR_TRAP_NPC: begin
        MUX_RFDest = DEST_R18;
        MUX_RFSrc  = SRC_NPC;
        wrState    = 1'b1;
      end
      default: begin
        MUX_RFDest = DEST_G0;
        MUX_RFSrc  = SRC_ALU;
        wrState    = 1'b0;
      end
    endcase
  end

  assign RF_Write_En = wrState & ~Stall;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: directed vector table, reset-abort sequence and
// random traffic compared against a queue-of-planned-writes reference model.
module tb_rf_write_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Norm_Req, Call_Req, Trap_Req, Stall;
  logic [4:0] IR_RD;
  logic [2:0] MUX_RFDest;
  logic [1:0] MUX_RFSrc;
  logic       RF_Write_En, Busy, Done;

  int checks   = 0;
  int failures = 0;

  // Packed expectation layout: {dest[2:0], src[1:0], we, busy, done}
  localparam logic [7:0] O_IDLE   = 8'b001_00_0_0_0;
  localparam logic [7:0] O_DONE   = 8'b001_00_0_1_1;
  localparam logic [7:0] O_NORM   = 8'b000_00_1_1_0;
  localparam logic [7:0] O_NORMST = 8'b000_00_0_1_0;
  localparam logic [7:0] O_G0     = 8'b001_00_0_1_0;
  localparam logic [7:0] O_CALL   = 8'b010_01_1_1_0;
  localparam logic [7:0] O_TPC    = 8'b011_01_1_1_0;
  localparam logic [7:0] O_TPCST  = 8'b011_01_0_1_0;
  localparam logic [7:0] O_TNPC   = 8'b100_10_1_1_0;

  rf_write_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Norm_Req(Norm_Req), .Call_Req(Call_Req), .Trap_Req(Trap_Req),
    .IR_RD(IR_RD), .Stall(Stall),
    .MUX_RFDest(MUX_RFDest), .MUX_RFSrc(MUX_RFSrc),
    .RF_Write_En(RF_Write_En), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       norm, call, trap;
    logic [4:0] rd;
    logic       stall;
    logic [7:0] exp;
  } vec_t;

  // Each planned step is either one write-port cycle or the Done pulse.
  typedef struct {
    bit         isDone;
    logic [2:0] dest;
    logic [1:0] src;
    logic       wr;
    bit         watchTrap;
  } step_t;

  vec_t  vecs[$];
  step_t plan[$];
  bit    pend;

  function automatic vec_t mk(logic n, logic c, logic t, logic [4:0] rd, logic s, logic [7:0] e);
    vec_t v;
    v.norm = n; v.call = c; v.trap = t; v.rd = rd; v.stall = s; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] modelOut(logic stall);
    step_t h;
    if (plan.size() == 0) return O_IDLE;
    h = plan[0];
    if (h.isDone) return O_DONE;
    return {h.dest, h.src, h.wr & ~stall, 1'b1, 1'b0};
  endfunction

  task automatic pushTrap();
    plan.push_back('{1'b0, 3'b011, 2'b01, 1'b1, 1'b0});
    plan.push_back('{1'b0, 3'b100, 2'b10, 1'b1, 1'b0});
    plan.push_back('{1'b1, 3'b001, 2'b00, 1'b0, 1'b0});
  endtask

  // Reference: requests turn into a plan of steps; a stalled write step stays at the head.
  task automatic modelAdvance(logic n, logic c, logic t, logic [4:0] rd, logic s);
    step_t h;
    if (plan.size() == 0) begin
      if (t) pushTrap();
      else if (c) begin
        plan.push_back('{1'b0, 3'b010, 2'b01, 1'b1, 1'b1});
        plan.push_back('{1'b1, 3'b001, 2'b00, 1'b0, 1'b0});
      end else if (n) begin
        if (rd == 5'd0) plan.push_back('{1'b0, 3'b001, 2'b00, 1'b0, 1'b1});
        else            plan.push_back('{1'b0, 3'b000, 2'b00, 1'b1, 1'b1});
        plan.push_back('{1'b1, 3'b001, 2'b00, 1'b0, 1'b0});
      end
    end else begin
      h = plan[0];
      if (h.isDone) begin
        void'(plan.pop_front());
        if (pend) begin
          pend = 1'b0;
          pushTrap();
        end
      end else begin
        if (h.watchTrap && t) pend = 1'b1;
        if (!s) void'(plan.pop_front());
      end
    end
  endtask

  task automatic modelReset();
    plan.delete();
    pend = 1'b0;
  endtask

  task automatic applyStimulus(logic n, logic c, logic t, logic [4:0] rd, logic s);
    Norm_Req = n; Call_Req = c; Trap_Req = t; IR_RD = rd; Stall = s;
    #1;
  endtask

  task automatic checkOutput(string name, logic [7:0] exp);
    logic [7:0] got;
    got = {MUX_RFDest, MUX_RFSrc, RF_Write_En, Busy, Done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got dest/src/we/busy/done=%b required %b", name, got, exp);
    end
  endtask

  task automatic asyncReset(string name);
    Reset_n = 1'b0;
    #1;
    checkOutput(name, O_IDLE);
    modelReset();
  endtask

  initial begin
    logic n, c, t, s;
    logic [4:0] rd;

    Reset_n = 1'b0;
    Norm_Req = 0; Call_Req = 0; Trap_Req = 0; IR_RD = 0; Stall = 0;
    modelReset();
    repeat (2) @(negedge Clk);
    checkOutput("reset_state", O_IDLE);
    Reset_n = 1'b1;

    vecs.push_back(mk(0,0,0,5'd0,1,O_IDLE));
    vecs.push_back(mk(1,0,0,5'd5,0,O_IDLE));
    vecs.push_back(mk(0,1,0,5'd0,0,O_NORM));
    vecs.push_back(mk(0,0,0,5'd0,1,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_IDLE));
    vecs.push_back(mk(1,0,0,5'd0,0,O_IDLE));
    vecs.push_back(mk(0,0,0,5'd9,0,O_G0));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_IDLE));
    vecs.push_back(mk(1,1,1,5'd7,0,O_IDLE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TNPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_IDLE));
    vecs.push_back(mk(0,0,1,5'd0,0,O_IDLE));
    vecs.push_back(mk(0,0,0,5'd0,1,O_TPCST));
    vecs.push_back(mk(0,0,1,5'd0,1,O_TPCST));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TNPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,1,0,5'd0,0,O_IDLE));
    vecs.push_back(mk(0,0,1,5'd0,0,O_CALL));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_TNPC));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,1,O_IDLE));
    vecs.push_back(mk(1,0,0,5'd9,0,O_IDLE));
    vecs.push_back(mk(1,0,0,5'd0,1,O_NORMST));
    vecs.push_back(mk(0,0,0,5'd0,0,O_NORM));
    vecs.push_back(mk(0,0,0,5'd0,0,O_DONE));
    vecs.push_back(mk(0,0,0,5'd0,0,O_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].norm, vecs[i].call, vecs[i].trap, vecs[i].rd, vecs[i].stall);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      modelAdvance(vecs[i].norm, vecs[i].call, vecs[i].trap, vecs[i].rd, vecs[i].stall);
      @(negedge Clk);
    end

    // Reset dropped in the middle of a trap entry must abort the R18 write.
    applyStimulus(0,0,1,5'd0,0);
    checkOutput("abort_req", O_IDLE);
    modelAdvance(0,0,1,5'd0,0);
    @(negedge Clk);
    applyStimulus(0,0,0,5'd0,0);
    checkOutput("abort_in_tpc", O_TPC);
    asyncReset("abort_reset_now");
    @(negedge Clk);
    applyStimulus(0,0,0,5'd0,0);
    checkOutput("abort_held", O_IDLE);
    Reset_n = 1'b1;
    @(negedge Clk);
    applyStimulus(0,0,0,5'd0,0);
    checkOutput("abort_no_r18", O_IDLE);
    @(negedge Clk);
    applyStimulus(1,0,0,5'd3,0);
    checkOutput("after_abort_req", O_IDLE);
    modelAdvance(1,0,0,5'd3,0);
    @(negedge Clk);
    applyStimulus(0,0,0,5'd0,0);
    checkOutput("after_abort_write", O_NORM);
    modelAdvance(0,0,0,5'd0,0);
    @(negedge Clk);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset("rand_reset");
        Reset_n = 1'b1;
      end
      t  = ($urandom_range(0, 99) < 12);
      c  = ($urandom_range(0, 99) < 20);
      n  = ($urandom_range(0, 99) < 45);
      s  = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      applyStimulus(n, c, t, rd, s);
      checkOutput($sformatf("rand%0d", i), modelOut(s));
      modelAdvance(n, c, t, rd, s);
      @(negedge Clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
